// File: rtl/ntr_responder_if.sv
// ntr_responder_if: NTR card-bus pins plus the valid/ready response byte stream
interface ntr_responder_if #(
    parameter int LEN_W = 13
);
    logic             ntr_clk;
    logic             ntr_cs1;
    logic [LEN_W-1:0] resp_len;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       ntr_data_out;
    logic             ntr_data_oe;
    logic             cmd_done;
    logic             busy;
    logic             underrun;
    modport slave (
        input  ntr_clk, ntr_cs1, resp_len, tx_data, tx_valid,
        output tx_ready, ntr_data_out, ntr_data_oe, cmd_done, busy, underrun
    );
    modport master (
        output ntr_clk, ntr_cs1, resp_len, tx_data, tx_valid,
        input  tx_ready, ntr_data_out, ntr_data_oe, cmd_done, busy, underrun
    );
endinterface

// File: rtl/ntr_responder.sv
// ntr_responder: NTR cartridge-side transmitter, counts command bytes then streams response bytes
module ntr_responder #(
    parameter int         CMD_BYTES = 8,
    parameter logic [7:0] FILL_BYTE = 8'hFF,
    parameter int         LEN_W     = 13
) (
    input logic            clk,
    input logic            rst_n,
    ntr_responder_if.slave bus
);
    localparam int CW = $clog2(CMD_BYTES) + 1;
    typedef enum logic [2:0] {IDLE, CMD, WAIT_DATA, DATA, DONE} state_t;
    state_t           state;
    logic [2:0]       clk_s;
    logic [1:0]       cs1_s;
    logic [CW-1:0]    byte_cnt;
    logic [LEN_W-1:0] remaining;
    logic             rise, fall, cs, load;
    // clk_s[1] is the synchronised level, clk_s[2] its one-cycle delay for edge detection
    assign rise = clk_s[1] & ~clk_s[2];
    assign fall = ~clk_s[1] & clk_s[2];
    assign cs   = ~cs1_s[1];
    assign load = rst_n & cs & fall &
                  ((state == WAIT_DATA && bus.resp_len != '0) || (state == DATA && remaining != '0));
    assign bus.tx_ready = load;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            clk_s            <= '1;
            cs1_s            <= '1;
            byte_cnt         <= '0;
            remaining        <= '0;
            bus.ntr_data_out <= '0;
            bus.ntr_data_oe  <= 1'b0;
            bus.cmd_done     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.underrun     <= 1'b0;
        end else begin
            clk_s        <= {clk_s[1:0], bus.ntr_clk};
            cs1_s        <= {cs1_s[0], bus.ntr_cs1};
            bus.cmd_done <= 1'b0;
            if (load) begin
                bus.ntr_data_out <= bus.tx_valid ? bus.tx_data : FILL_BYTE;
                if (!bus.tx_valid) bus.underrun <= 1'b1;
            end
            // chip-select release aborts whatever is in flight, ahead of any bus edge
            if (state != IDLE && !cs) begin
                state           <= IDLE;
                bus.ntr_data_oe <= 1'b0;
                bus.busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (cs) begin
                        state        <= CMD;
                        bus.busy     <= 1'b1;
                        byte_cnt     <= '0;
                        bus.underrun <= 1'b0;
                    end
                    CMD: if (rise) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == CW'(CMD_BYTES - 1)) begin
                            bus.cmd_done <= 1'b1;
                            state        <= WAIT_DATA;
                        end
                    end
                    WAIT_DATA: if (fall) begin
                        if (bus.resp_len == '0) state <= DONE;
                        else begin
                            bus.ntr_data_oe <= 1'b1;
                            remaining       <= bus.resp_len - 1'b1;
                            state           <= DATA;
                        end
                    end
                    DATA: begin
                        if (fall && remaining != '0) remaining <= remaining - 1'b1;
                        else if (rise && remaining == '0) begin
                            bus.ntr_data_oe <= 1'b0;
                            state           <= DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ntr_responder.sv
// tb_ntr_responder: console-side bus driver, stream source and reference model for ntr_responder
module tb_ntr_responder;
    localparam int H = 5;
    localparam logic [7:0] FILL = 8'hFF;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_ready = 0;
    int   n_done = 0;
    int   src_idx = 0;
    int   ld_idx = 0;
    logic [7:0] src_q[$];
    bit         plan[$];
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    bit         exp_un;
    ntr_responder_if bus ();
    ntr_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    initial forever begin
        @(negedge clk);
        if (bus.tx_ready === 1'b1) n_ready++;
        if (bus.cmd_done === 1'b1) n_done++;
    end
    task automatic drive_src();
        bus.tx_valid = (ld_idx < plan.size() ? plan[ld_idx] : 1'b1) && src_idx < src_q.size();
        bus.tx_data  = src_idx < src_q.size() ? src_q[src_idx] : 8'h00;
    endtask
    // upstream byte source: advances only on an accepted handshake
    initial forever begin
        @(negedge clk);
        if (bus.tx_ready === 1'b1) begin
            if (bus.tx_valid) src_idx++;
            ld_idx++;
            @(posedge clk);
            #1;
            drive_src();
        end
    end
    task automatic set_stream(input int len);
        src_idx = 0;
        ld_idx = 0;
        bus.resp_len = 13'(len);
        drive_src();
        n_ready = 0;
        n_done = 0;
    endtask
    // expected console samples: each byte slot takes the next stream byte if offered, else the fill byte
    function automatic void model(input int len);
        int si = 0;
        exp_q.delete();
        exp_un = 0;
        for (int k = 0; k < len; k++) begin
            if ((k < plan.size() ? plan[k] : 1'b1) && si < src_q.size()) exp_q.push_back(src_q[si++]);
            else begin
                exp_q.push_back(FILL);
                exp_un = 1;
            end
        end
    endfunction
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic cs_low();
        cap.delete();
        bus.ntr_cs1 = 1'b0;
        clks(6);
    endtask
    task automatic cs_high();
        bus.ntr_cs1 = 1'b1;
        clks(4);
    endtask
    task automatic pulses(input int n, input bit smp);
        repeat (n) begin
            bus.ntr_clk = 1'b0;
            clks(H);
            if (smp && bus.ntr_data_oe === 1'b1) cap.push_back(bus.ntr_data_out);
            bus.ntr_clk = 1'b1;
            clks(H);
        end
    endtask
    task automatic test_reset();
        bus.ntr_cs1 = 1'b0;
        bus.ntr_clk = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'h5A;
        bus.resp_len = 13'd4;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i % 3 == 0) bus.ntr_clk = ~bus.ntr_clk;
            n_checks += 3;
            if (bus.ntr_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b, expected 0", bus.ntr_data_oe); end
            if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
            if (bus.tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready: got %b, expected 0", bus.tx_ready); end
        end
        n_checks += 3;
        if (bus.ntr_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, expected 00", bus.ntr_data_out); end
        if (bus.underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b, expected 0", bus.underrun); end
        if (bus.cmd_done !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_done: got %b, expected 0", bus.cmd_done); end
        bus.ntr_cs1 = 1'b1;
        bus.ntr_clk = 1'b1;
        bus.tx_valid = 1'b0;
        clks(2);
        rst_n = 1'b1;
        clks(4);
    endtask
    task automatic check_xfer(input string name, input int len);
        model(len);
        n_checks += 4;
        if (n_done !== 1) begin n_fail++; $display("FAIL %s_cmd_done: got %0d pulses, expected 1", name, n_done); end
        if (n_ready !== len) begin n_fail++; $display("FAIL %s_tx_ready: got %0d pulses, expected %0d", name, n_ready, len); end
        if (cap.size() !== exp_q.size()) begin n_fail++; $display("FAIL %s_count: got %0d bytes, expected %0d", name, cap.size(), exp_q.size()); end
        if (bus.underrun !== exp_un) begin n_fail++; $display("FAIL %s_underrun: got %b, expected %b", name, bus.underrun, exp_un); end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_checks++;
            if (cap[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s_byte%0d: got %h, expected %h", name, i, cap[i], exp_q[i]); end
        end
    endtask
    task automatic check_idle(input string name);
        n_checks += 2;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b, expected 0", name, bus.busy); end
        if (bus.ntr_data_oe !== 1'b0) begin n_fail++; $display("FAIL %s_oe: got %b, expected 0", name, bus.ntr_data_oe); end
    endtask
    task automatic test_basic();
        src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        plan.delete();
        set_stream(4);
        cs_low();
        pulses(8, 0);
        pulses(5, 1);
        check_xfer("basic", 4);
        cs_high();
        check_idle("basic_end");
    endtask
    task automatic test_underrun();
        src_q = '{8'hD0, 8'hD2};
        plan = '{1, 0, 1};
        set_stream(3);
        cs_low();
        pulses(8, 0);
        pulses(4, 1);
        check_xfer("underrun", 3);
        cs_high();
        cs_low();
        n_checks++;
        if (bus.underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear: got %b, expected 0", bus.underrun); end
        cs_high();
    endtask
    task automatic test_zero_len();
        src_q = '{8'h11, 8'h22};
        plan.delete();
        set_stream(0);
        cs_low();
        pulses(8, 0);
        pulses(3, 1);
        n_checks += 4;
        if (n_done !== 1) begin n_fail++; $display("FAIL zero_cmd_done: got %0d pulses, expected 1", n_done); end
        if (n_ready !== 0) begin n_fail++; $display("FAIL zero_tx_ready: got %0d pulses, expected 0", n_ready); end
        if (cap.size() !== 0) begin n_fail++; $display("FAIL zero_oe: got %0d driven bytes, expected 0", cap.size()); end
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL zero_done_busy: got %b, expected 1", bus.busy); end
        cs_high();
        check_idle("zero_end");
    endtask
    task automatic test_data_abort();
        src_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        plan.delete();
        set_stream(6);
        cs_low();
        pulses(8, 0);
        pulses(2, 1);
        cs_high();
        check_idle("data_abort");
        pulses(3, 0);
        n_checks += 3;
        if (n_ready !== 2) begin n_fail++; $display("FAIL data_abort_tx_ready: got %0d pulses, expected 2", n_ready); end
        if (cap.size() !== 2) begin n_fail++; $display("FAIL data_abort_count: got %0d bytes, expected 2", cap.size()); end
        else if (cap[0] !== 8'h31 || cap[1] !== 8'h32) begin n_fail++; $display("FAIL data_abort_bytes: got %h %h, expected 31 32", cap[0], cap[1]); end
        if (bus.ntr_data_oe !== 1'b0) begin n_fail++; $display("FAIL data_abort_oe_hold: got %b, expected 0", bus.ntr_data_oe); end
    endtask
    task automatic test_cmd_abort();
        src_q = '{8'h7E};
        plan.delete();
        set_stream(1);
        cs_low();
        pulses(5, 0);
        cs_high();
        check_idle("cmd_abort");
        cs_low();
        pulses(7, 0);
        n_checks++;
        if (n_done !== 0) begin n_fail++; $display("FAIL cmd_abort_early_done: got %0d pulses, expected 0", n_done); end
        pulses(1, 0);
        pulses(2, 1);
        check_xfer("cmd_abort", 1);
        cs_high();
    endtask
    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int len = $urandom_range(1, 12);
            int ns = $urandom_range(len / 2, len);
            src_q.delete();
            plan.delete();
            for (int i = 0; i < ns; i++) src_q.push_back(8'($urandom));
            for (int i = 0; i < len; i++) plan.push_back($urandom_range(0, 3) != 0);
            set_stream(len);
            cs_low();
            pulses(8, 0);
            bus.resp_len = 13'($urandom);
            #0;
            bus.resp_len = 13'(len);
            pulses(len + 1, 1);
            bus.resp_len = 13'($urandom_range(1, 4000));
            pulses(1, 1);
            check_xfer($sformatf("random%0d", it), len);
            cs_high();
            check_idle($sformatf("random%0d_end", it));
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_zero_len();
        test_data_abort();
        test_cmd_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
